// File: rtl/digit_match_pkg.sv
// Purpose: shared constants and the FSM state type for the digit template matcher.
// Contents: grid/image geometry, accumulator and address widths, match threshold,
//           and dm_state_t, the sequencer state encoding.
package digit_match_pkg;

  localparam int NUM_DIGITS = 10;
  localparam int GRID       = 11;
  localparam int PIXELS     = GRID * GRID;  // 121, row-major, addr = row*GRID+col
  localparam int SCORE_W    = 16;           // 121*255 = 30855 fits, never saturates
  localparam int THRESH     = 4000;
  localparam int IMG_AW     = 7;
  localparam int TPL_AW     = 11;           // NUM_DIGITS*PIXELS = 1210 entries
  localparam int DIGIT_W    = 4;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } dm_state_t;

endpackage

// File: rtl/pixel_absdiff.sv
// Purpose: combinational 8-bit absolute difference |a - b|.
// Ports:
//   a_i    in  8  first operand (image pixel)
//   b_i    in  8  second operand (template pixel)
//   diff_o out 8  |a_i - b_i|
module pixel_absdiff
  import digit_match_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] diff_o
);

  assign diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/digit_match_sequencer.sv
// Purpose: matches one 11x11 8-bit image against NUM_DIGITS templates through one
//          time-shared absolute-difference unit, one pixel per cycle, and reports the
//          lowest-scoring digit.
// Ports:
//   clk         in   1        rising-edge clock
//   reset_n     in   1        synchronous active-low reset
//   start       in   1        request a run, sampled only in IDLE
//   abort       in   1        cancel a run in progress (wins over start in IDLE)
//   img_addr    out  7        image buffer read address (pixel)
//   img_data    in   8        image pixel, valid one cycle after img_addr
//   tpl_addr    out  11       template ROM address = digit*PIXELS + pixel
//   tpl_data    in   8        template pixel, valid one cycle after tpl_addr
//   busy        out  1        run in progress (RUN or DRAIN)
//   done        out  1        one-cycle pulse; results valid from this cycle
//   best_digit  out  4        digit with the lowest score
//   best_score  out  16       lowest score
//   match_valid out  1        best_score <= THRESH
//   dbg_state   out  2        current FSM state, for observation only
//
// Handshake: there is no back-pressure. Read addresses are issued once per cycle
// in RUN and the memories must return data exactly one cycle later; the stage-2
// valid register marks which cycles carry a returned pixel pair.
module digit_match_sequencer
  import digit_match_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic [IMG_AW-1:0]  img_addr,
  input  logic [PIX_W-1:0]   img_data,
  output logic [TPL_AW-1:0]  tpl_addr,
  input  logic [PIX_W-1:0]   tpl_data,
  output logic               busy,
  output logic               done,
  output logic [DIGIT_W-1:0] best_digit,
  output logic [SCORE_W-1:0] best_score,
  output logic               match_valid,
  output dm_state_t          dbg_state
);

  dm_state_t            state_q, state_d;
  logic [IMG_AW-1:0]    pix_q, pix_d;
  logic [DIGIT_W-1:0]   dig_q, dig_d;
  logic [IMG_AW-1:0]    img_addr_q, img_addr_d;
  logic [TPL_AW-1:0]    tpl_addr_q, tpl_addr_d;
  // Stage-2 pipe: describes the pixel pair whose data arrives this cycle.
  logic                 v2_q, v2_d;
  logic                 first2_q, first2_d;
  logic                 last2_q, last2_d;
  logic [DIGIT_W-1:0]   dig2_q, dig2_d;
  logic [SCORE_W-1:0]   acc_q, acc_d;
  logic [SCORE_W-1:0]   run_best_q, run_best_d;
  logic [DIGIT_W-1:0]   run_dig_q, run_dig_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [DIGIT_W-1:0]   best_digit_q, best_digit_d;
  logic                 match_q, match_d;

  logic [PIX_W-1:0]     diff;
  logic [SCORE_W-1:0]   sum;
  logic                 upd;
  logic [SCORE_W-1:0]   cur_best;
  logic [DIGIT_W-1:0]   cur_dig;
  logic                 last_issue;

  pixel_absdiff u_absdiff (
    .a_i    (img_data),
    .b_i    (tpl_data),
    .diff_o (diff)
  );

  assign last_issue = (dig_q == DIGIT_W'(NUM_DIGITS - 1)) && (pix_q == IMG_AW'(PIXELS - 1));
  assign sum        = (first2_q ? '0 : acc_q) + SCORE_W'(diff);
  // The last pixel's score is compared in the same cycle it completes; strict
  // less-than keeps the lowest digit on ties.
  assign upd        = v2_q && last2_q && (sum < run_best_q);
  assign cur_best   = upd ? sum : run_best_q;
  assign cur_dig    = upd ? dig2_q : run_dig_q;

  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    dig_d        = dig_q;
    img_addr_d   = img_addr_q;
    tpl_addr_d   = tpl_addr_q;
    v2_d         = (state_q == RUN) && !abort;
    first2_d     = (pix_q == '0);
    last2_d      = (pix_q == IMG_AW'(PIXELS - 1));
    dig2_d       = dig_q;
    acc_d        = v2_q ? sum : acc_q;
    run_best_d   = cur_best;
    run_dig_d    = cur_dig;
    best_score_d = best_score_q;
    best_digit_d = best_digit_q;
    match_d      = match_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = RUN;
          pix_d      = '0;
          dig_d      = '0;
          img_addr_d = '0;
          tpl_addr_d = '0;
          run_best_d = '1;
          run_dig_d  = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (last_issue) begin
          state_d = DRAIN;
        end else begin
          if (pix_q == IMG_AW'(PIXELS - 1)) begin
            pix_d = '0;
            dig_d = dig_q + DIGIT_W'(1);
          end else begin
            pix_d = pix_q + IMG_AW'(1);
          end
          img_addr_d = pix_d;
          // Issue order is strictly sequential, so the ROM address just counts.
          tpl_addr_d = tpl_addr_q + TPL_AW'(1);
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d      = FINISH;
          best_score_d = cur_best;
          best_digit_d = cur_dig;
          match_d      = (cur_best <= SCORE_W'(THRESH));
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pix_q        <= '0;
      dig_q        <= '0;
      img_addr_q   <= '0;
      tpl_addr_q   <= '0;
      v2_q         <= 1'b0;
      first2_q     <= 1'b0;
      last2_q      <= 1'b0;
      dig2_q       <= '0;
      acc_q        <= '0;
      run_best_q   <= '1;
      run_dig_q    <= '0;
      best_score_q <= '0;
      best_digit_q <= '0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      dig_q        <= dig_d;
      img_addr_q   <= img_addr_d;
      tpl_addr_q   <= tpl_addr_d;
      v2_q         <= v2_d;
      first2_q     <= first2_d;
      last2_q      <= last2_d;
      dig2_q       <= dig2_d;
      acc_q        <= acc_d;
      run_best_q   <= run_best_d;
      run_dig_q    <= run_dig_d;
      best_score_q <= best_score_d;
      best_digit_q <= best_digit_d;
      match_q      <= match_d;
    end
  end

  assign img_addr    = img_addr_q;
  assign tpl_addr    = tpl_addr_q;
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == FINISH);
  assign best_digit  = best_digit_q;
  assign best_score  = best_score_q;
  assign match_valid = match_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_digit_match_sequencer.sv
// Directed bench for digit_match_sequencer: image RAM and template ROM models with
// one-cycle read latency, one task per scenario, inline comparisons.
module tb_digit_match_sequencer;
  import digit_match_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start;
  logic               abort;
  logic [IMG_AW-1:0]  img_addr;
  logic [PIX_W-1:0]   img_data;
  logic [TPL_AW-1:0]  tpl_addr;
  logic [PIX_W-1:0]   tpl_data;
  logic               busy;
  logic               done;
  logic [DIGIT_W-1:0] best_digit;
  logic [SCORE_W-1:0] best_score;
  logic               match_valid;
  dm_state_t          dbg_state;

  logic [PIX_W-1:0] img_mem [PIXELS];
  logic [PIX_W-1:0] tpl_mem [NUM_DIGITS*PIXELS];

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  digit_match_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .img_addr    (img_addr),
    .img_data    (img_data),
    .tpl_addr    (tpl_addr),
    .tpl_data    (tpl_data),
    .busy        (busy),
    .done        (done),
    .best_digit  (best_digit),
    .best_score  (best_score),
    .match_valid (match_valid),
    .dbg_state   (dbg_state)
  );

  // Memory models: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    img_data <= img_mem[img_addr];
    tpl_data <= tpl_mem[tpl_addr];
  end

  // ---------------- driver tasks ----------------
  task automatic load_uniform(input logic [7:0] img_val, input int tpl_step);
    for (int p = 0; p < PIXELS; p++) img_mem[p] = img_val;
    for (int d = 0; d < NUM_DIGITS; d++)
      for (int p = 0; p < PIXELS; p++) tpl_mem[d*PIXELS+p] = 8'(tpl_step * d);
  endtask

  // Pulses start in cycle 0, then runs cycles 1..max_cyc. In each cycle it first
  // samples outputs, then sets the inputs for that cycle (restart/abort/reset).
  task automatic drive_run(input int restart_cyc, input int abort_cyc, input int rst_cyc,
                           input int max_cyc,
                           output int done_first, output int done_cnt,
                           output int busy_cnt, output int busy_low_first,
                           output int addr_bad, output int addr_bad_cyc);
    int cyc;
    int stop;
    int exp_img;
    int exp_tpl;
    done_first = 0; done_cnt = 0; busy_cnt = 0; busy_low_first = 0;
    addr_bad = 0; addr_bad_cyc = 0;
    stop = 1210;
    if (abort_cyc != 0 && abort_cyc < stop) stop = abort_cyc;
    if (rst_cyc != 0 && rst_cyc < stop) stop = rst_cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc <= max_cyc) begin
      if (done) begin
        done_cnt++;
        if (done_first == 0) done_first = cyc;
      end
      if (busy) busy_cnt++;
      else if (busy_low_first == 0) busy_low_first = cyc;
      if (cyc <= stop) begin
        exp_img = (cyc - 1) % PIXELS;
        exp_tpl = ((cyc - 1) / PIXELS) * PIXELS + exp_img;
        if (int'(img_addr) != exp_img || int'(tpl_addr) != exp_tpl) begin
          addr_bad++;
          if (addr_bad_cyc == 0) addr_bad_cyc = cyc;
        end
      end
      start   = (cyc == restart_cyc);
      abort   = (cyc == abort_cyc);
      reset_n = !(cyc == rst_cyc);
      if (cyc == max_cyc) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0; reset_n = 1'b1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || match_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b match_valid=%b, expected 0 0 0", busy, done, match_valid);
    end
    checks++;
    if (best_digit !== 4'd0 || best_score !== 16'd0) begin
      errors++;
      $display("FAIL reset_results: digit=%0d score=%0d, expected 0 0", best_digit, best_score);
    end
    checks++;
    if (img_addr !== 7'd0 || tpl_addr !== 11'd0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_addr_state: img=%0d tpl=%0d state=%0d, expected 0 0 0", img_addr, tpl_addr, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_nearest();
    int df, dc, bc, blf, ab, abc;
    load_uniform(8'd60, 20);
    drive_run(0, 0, 0, 1215, df, dc, bc, blf, ab, abc);
    checks++;
    if (df != 1212 || dc != 1) begin
      errors++;
      $display("FAIL nearest_done: first=%0d count=%0d, expected 1212 1", df, dc);
    end
    checks++;
    if (bc != 1211 || blf != 1212) begin
      errors++;
      $display("FAIL nearest_busy: high_cycles=%0d first_low=%0d, expected 1211 1212", bc, blf);
    end
    checks++;
    if (ab != 0) begin
      errors++;
      $display("FAIL nearest_addr_seq: %0d bad cycles, first at %0d, expected 0", ab, abc);
    end
    checks++;
    if (best_digit !== 4'd3 || best_score !== 16'd0 || match_valid !== 1'b1) begin
      errors++;
      $display("FAIL nearest_result: digit=%0d score=%0d mv=%b, expected 3 0 1", best_digit, best_score, match_valid);
    end
  endtask

  task automatic test_max_score();
    int df, dc, bc, blf, ab, abc;
    load_uniform(8'd255, 0);
    drive_run(0, 0, 0, 1215, df, dc, bc, blf, ab, abc);
    checks++;
    if (df != 1212 || dc != 1) begin
      errors++;
      $display("FAIL maxscore_done: first=%0d count=%0d, expected 1212 1", df, dc);
    end
    checks++;
    if (best_digit !== 4'd0 || best_score !== 16'd30855 || match_valid !== 1'b0) begin
      errors++;
      $display("FAIL maxscore_result: digit=%0d score=%0d mv=%b, expected 0 30855 0", best_digit, best_score, match_valid);
    end
  endtask

  task automatic test_tie();
    int df, dc, bc, blf, ab, abc;
    for (int p = 0; p < PIXELS; p++) img_mem[p] = 8'((p * 7) % 256);
    for (int d = 0; d < NUM_DIGITS; d++)
      for (int p = 0; p < PIXELS; p++)
        tpl_mem[d*PIXELS+p] = (d == 2 || d == 5) ? img_mem[p] : (img_mem[p] ^ 8'h01);
    drive_run(0, 0, 0, 1215, df, dc, bc, blf, ab, abc);
    checks++;
    if (best_digit !== 4'd2 || best_score !== 16'd0 || match_valid !== 1'b1) begin
      errors++;
      $display("FAIL tie_result: digit=%0d score=%0d mv=%b, expected 2 0 1", best_digit, best_score, match_valid);
    end
  endtask

  task automatic test_back_to_back_start();
    int df, dc, bc, blf, ab, abc;
    drive_run(300, 0, 0, 1300, df, dc, bc, blf, ab, abc);
    checks++;
    if (df != 1212 || dc != 1 || bc != 1211) begin
      errors++;
      $display("FAIL restart_ignored: done_first=%0d done_count=%0d busy_cycles=%0d, expected 1212 1 1211", df, dc, bc);
    end
    checks++;
    if (ab != 0) begin
      errors++;
      $display("FAIL restart_addr_seq: %0d bad cycles, first at %0d, expected 0", ab, abc);
    end
    checks++;
    if (best_digit !== 4'd2 || best_score !== 16'd0) begin
      errors++;
      $display("FAIL restart_result: digit=%0d score=%0d, expected 2 0", best_digit, best_score);
    end
  endtask

  task automatic test_abort();
    int df, dc, bc, blf, ab, abc;
    load_uniform(8'd255, 0);
    drive_run(0, 500, 0, 1300, df, dc, bc, blf, ab, abc);
    checks++;
    if (dc != 0 || blf != 501 || bc != 500) begin
      errors++;
      $display("FAIL abort_timing: done_count=%0d first_low=%0d busy_cycles=%0d, expected 0 501 500", dc, blf, bc);
    end
    checks++;
    if (best_digit !== 4'd2 || best_score !== 16'd0 || match_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold: digit=%0d score=%0d mv=%b, expected 2 0 1", best_digit, best_score, match_valid);
    end
    drive_run(0, 0, 0, 1215, df, dc, bc, blf, ab, abc);
    checks++;
    if (df != 1212 || dc != 1 || ab != 0) begin
      errors++;
      $display("FAIL abort_rerun_done: first=%0d count=%0d addr_bad=%0d, expected 1212 1 0", df, dc, ab);
    end
    checks++;
    if (best_digit !== 4'd0 || best_score !== 16'd30855 || match_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_rerun_result: digit=%0d score=%0d mv=%b, expected 0 30855 0", best_digit, best_score, match_valid);
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b state=%0d, expected 0 0", busy, dbg_state);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle_after: busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    int df, dc, bc, blf, ab, abc;
    drive_run(0, 0, 700, 701, df, dc, bc, blf, ab, abc);
    checks++;
    if (ab != 0) begin
      errors++;
      $display("FAIL midreset_addr_seq: %0d bad cycles, first at %0d, expected 0", ab, abc);
    end
    checks++;
    if (blf != 701 || dc != 0 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL midreset_state: first_low=%0d done_count=%0d busy=%b done=%b state=%0d, expected 701 0 0 0 0",
               blf, dc, busy, done, dbg_state);
    end
    checks++;
    if (best_digit !== 4'd0 || best_score !== 16'd0 || match_valid !== 1'b0 ||
        img_addr !== 7'd0 || tpl_addr !== 11'd0) begin
      errors++;
      $display("FAIL midreset_outputs: digit=%0d score=%0d mv=%b img=%0d tpl=%0d, expected 0 0 0 0 0",
               best_digit, best_score, match_valid, img_addr, tpl_addr);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nearest();
    test_max_score();
    test_tie();
    test_back_to_back_start();
    test_abort();
    test_start_abort_idle();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
